// File: rtl/mix_col_sched_if.sv
// Handshake bundle for mix_col_sched: input state channel, output state channel and busy status.
// Optional MIXCOL_INV_EN adds the in_inv transform select to the input channel.
interface mix_col_sched_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic               in_bypass;
`ifdef MIXCOL_INV_EN
  logic               in_inv;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;
  logic               busy;

`ifdef MIXCOL_INV_EN
  modport master (output in_valid, state_in, in_bypass, in_inv, out_ready,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, in_bypass, in_inv, out_ready,
                  output in_ready, out_valid, state_out, busy);
`else
  modport master (output in_valid, state_in, in_bypass, out_ready,
                  input  in_ready, out_valid, state_out, busy);
  modport slave  (input  in_valid, state_in, in_bypass, out_ready,
                  output in_ready, out_valid, state_out, busy);
`endif
endinterface

// File: rtl/mix_col_sched.sv
// Column-serial AES MixColumns: one shared column unit rewrites the state register in place.
// Define MIXCOL_INV_EN to add the per-transfer InvMixColumns select (in_inv).
module mix_col_sched (
  input  logic           clk,
  input  logic           rst,
  mix_col_sched_if.slave bus
);
  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned BASE_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [BASE_W-1:0]  col_base;
  logic [COL_W-1:0]   col_cur, col_mix;
  logic               inv_sel;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte: forward 2/3/1/1 or inverse e/b/d/9 over rotated inputs a,b,c,d.
  function automatic logic [7:0] mix_row(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic inv);
    logic [7:0] a2, a4, a8, b2, b4, b8, c2, c4, c8, d2, d4, d8;
    a2 = xt(a); a4 = xt(a2); a8 = xt(a4);
    b2 = xt(b); b4 = xt(b2); b8 = xt(b4);
    c2 = xt(c); c4 = xt(c2); c8 = xt(c4);
    d2 = xt(d); d4 = xt(d2); d8 = xt(d4);
    if (inv)
      return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    return a2 ^ (b2 ^ b) ^ c ^ d;
  endfunction

  // Row bytes sit at [7:0], [31:24], [23:16], [15:8] for rows 0..3.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] r0, r1, r2, r3;
    r0 = col[7:0];
    r1 = col[31:24];
    r2 = col[23:16];
    r3 = col[15:8];
    return {mix_row(r1, r2, r3, r0, inv), mix_row(r2, r3, r0, r1, inv),
            mix_row(r3, r0, r1, r2, inv), mix_row(r0, r1, r2, r3, inv)};
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (state_q == S_IDLE && bus.in_valid)
      inv_d = bus.in_inv;
  end

  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_d;
  end

  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  assign col_base = {col_cnt_q, 5'd0};
  assign col_cur  = data_q[col_base +: COL_W];
  assign col_mix  = mix_col(col_cur, inv_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      col_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      col_cnt_q   <= col_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    col_cnt_d = col_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d    = bus.state_in;
          col_cnt_d = '0;
          state_d   = bus.in_bypass ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        data_d[col_base +: COL_W] = col_mix;
        col_cnt_d = CNT_W'(col_cnt_q + 1'b1);
        if (col_cnt_q == 2'd3)
          state_d = S_DONE;
      end
      S_DONE: begin
        // Only a presented result can be consumed.
        if (out_valid_q && bus.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bypass capture lands in DONE directly, so its valid is raised one cycle later.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE) && (state_q != S_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.state_out = data_q;
endmodule

// File: tb/tb_mix_col_sched.sv
// Directed self-checking bench for mix_col_sched: vectors, backpressure, bypass, reset mid-run.
module tb_mix_col_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mix_col_sched_if bus();
  mix_col_sched dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] V0_IN = 32'h135345db, V0_OUT = 32'h4da1bc8e;
  localparam logic [31:0] V1_IN = 32'h0a225cf2, V1_OUT = 32'hdc589d9f;
  localparam logic [31:0] V2_IN = 32'hd4d4d5d4, V2_OUT = 32'hd5d7d6d5;
  localparam logic [31:0] V3_IN = 32'hc6c6c6c6, V3_OUT = 32'hc6c6c6c6;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after acceptance edge E.
  task automatic send(input logic [127:0] s, input logic byp);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.state_in  = s;
    bus.in_bypass = byp;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drain_ov"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_drain_ir"}, 128'(bus.in_ready), 128'd1);
  endtask

  task automatic run_vec(input string tag, input logic [127:0] s, input logic [127:0] exp);
    send(s, 1'b0);
    check({tag, "_busy_e"}, 128'(bus.busy), 128'd1);
    repeat (3) tick();
    check({tag, "_ov_e3"}, 128'(bus.out_valid), 128'd0);
    tick();
    check({tag, "_ov_e4"}, 128'(bus.out_valid), 128'd1);
    check({tag, "_busy_e4"}, 128'(bus.busy), 128'd0);
    check({tag, "_data"}, bus.state_out, exp);
    drain(tag);
  endtask

  initial begin
    logic [127:0] mixed_in, mixed_out, next_in, byp_state;
    logic         ov_seen, busy_seen;
`ifdef MIXCOL_INV_EN
    logic [127:0] orig, fwd;
    bus.in_inv = 1'b0;
`endif
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.state_in  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_ir", 128'(bus.in_ready), 128'd1);
    check("rst_ov", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_data", bus.state_out, 128'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ir", 128'(bus.in_ready), 128'd1);
      check("idle_ov", 128'(bus.out_valid), 128'd0);
      check("idle_data", bus.state_out, 128'd0);
    end

    run_vec("v0", {4{V0_IN}}, {4{V0_OUT}});
    run_vec("v1", {4{V1_IN}}, {4{V1_OUT}});
    run_vec("v2", {4{V2_IN}}, {4{V2_OUT}});
    run_vec("v3", {4{V3_IN}}, {4{V3_OUT}});

    // Mixed columns with backpressure, then a state offered while DONE.
    mixed_in  = {V3_IN, V2_IN, V1_IN, V0_IN};
    mixed_out = {V3_OUT, V2_OUT, V1_OUT, V0_OUT};
    next_in   = {4{V2_IN}};
    send(mixed_in, 1'b0);
    repeat (4) tick();
    check("mix_ov", 128'(bus.out_valid), 128'd1);
    check("mix_data", bus.state_out, mixed_out);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov", 128'(bus.out_valid), 128'd1);
      check("bp_data", bus.state_out, mixed_out);
    end
    bus.in_valid  = 1'b1;
    bus.state_in  = next_in;
    bus.out_ready = 1'b1;
    check("done_ir", 128'(bus.in_ready), 128'd0);
    tick();
    bus.out_ready = 1'b0;
    check("d_ov", 128'(bus.out_valid), 128'd0);
    check("d_ir", 128'(bus.in_ready), 128'd1);
    check("d_no_capture", bus.state_out, mixed_out);
    tick();
    bus.in_valid = 1'b0;
    check("d1_busy", 128'(bus.busy), 128'd1);
    check("d1_ir", 128'(bus.in_ready), 128'd0);
    check("d1_capture", bus.state_out, next_in);
    repeat (3) tick();
    check("next_ov_e3", 128'(bus.out_valid), 128'd0);
    tick();
    check("next_ov_e4", 128'(bus.out_valid), 128'd1);
    check("next_data", bus.state_out, {4{V2_OUT}});
    drain("next");

    // Bypass returns the captured state untouched one cycle after acceptance.
    byp_state = 128'h0123456789abcdef_fedcba9876543210;
    send(byp_state, 1'b1);
    check("byp_ov_e", 128'(bus.out_valid), 128'd0);
    busy_seen = bus.busy;
    tick();
    busy_seen = busy_seen | bus.busy;
    check("byp_ov_e1", 128'(bus.out_valid), 128'd1);
    check("byp_data", bus.state_out, byp_state);
    drain("byp");
    busy_seen = busy_seen | bus.busy;
    check("byp_busy", 128'(busy_seen), 128'd0);

    // Reset at E+2 discards the in-flight state.
    send({4{V1_IN}}, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_data", bus.state_out, 128'd0);
    check("mrst_ir", 128'(bus.in_ready), 128'd1);
    check("mrst_busy", 128'(bus.busy), 128'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ov_seen = ov_seen | bus.out_valid;
    end
    check("mrst_no_ov", 128'(ov_seen), 128'd0);
    run_vec("post_rst", {V0_IN, V1_IN, V2_IN, V3_IN}, {V0_OUT, V1_OUT, V2_OUT, V3_OUT});

`ifdef MIXCOL_INV_EN
    bus.in_inv = 1'b1;
    run_vec("inv", {4{V0_OUT}}, {4{V0_IN}});
    bus.in_inv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      bus.in_inv = 1'b0;
      send(orig, 1'b0);
      repeat (4) tick();
      fwd = bus.state_out;
      drain("rt_fwd");
      bus.in_inv = 1'b1;
      send(fwd, 1'b0);
      repeat (4) tick();
      check("roundtrip", bus.state_out, orig);
      drain("rt_inv");
      bus.in_inv = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mix_col_sched.md
# mix_col_sched

Column-serial MixColumns engine for the AES round datapath. It accepts a 128-bit state over a valid/ready handshake and applies MixColumns one 32-bit column per clock through a single shared column unit. It returns the result over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey, and the round controller uses it when area matters more than the four-cycle latency. A per-transfer bypass serves the final AES round, which omits MixColumns.

## Interface
- No parameters; widths are fixed by AES.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `state_in`/`in_bypass` valid.
- `in_ready` out 1: block can accept a state.
- `state_in` in 128: state after ShiftRows.
- `in_bypass` in 1: sampled with the transfer; 1 = pass the state through unmodified (final round).
- `out_valid` out 1: `state_out` holds a finished result.
- `out_ready` in 1: consumer accepts the result.
- `state_out` out 128: result state, driven from the internal state register.
- `busy` out 1: high in RUN.
- Clock `clk`, reset `rst`; one clock; reset is synchronous and active-high.

## Operation
- Byte map is identical for the input and the output. Column c occupies bits [32c+31:32c].
  - row0 = [32c+7:32c]
  - row1 = [32c+31:32c+24]
  - row2 = [32c+23:32c+16]
  - row3 = [32c+15:32c+8]
- Forward column transform: r0'=2r0^3r1^r2^r3, r1'=r0^2r1^3r2^r3, r2'=r0^r1^2r2^3r3, r3'=3r0^r1^r2^2r3.
- GF(2^8) arithmetic uses modulus 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0). All results are 8 bits.
- One column unit only. It reads column `col_cnt` of the state register and writes the result back in place.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, the state is captured into the register. If `in_bypass`=1, go to DONE. Otherwise clear `col_cnt` and go to RUN.
  - RUN: each cycle transform column `col_cnt`, then increment it. The cycle with `col_cnt`=3 writes column 3 and goes to DONE. `col_cnt` is 2 bits and wraps to 0.
  - DONE: `out_valid`=1 and `state_out` is held stable. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. There is no acceptance in DONE, even when `out_ready` is high in the same cycle.
- `out_ready` outside DONE is ignored. `in_valid` outside IDLE is ignored; the producer holds it until `in_ready`.
- Reset, including mid-RUN or in DONE: next state IDLE, state register = 0, `col_cnt` = 0. Any in-flight state is discarded and no `out_valid` pulse is issued for it.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `state_out`=128'h0.
- Acceptance is the edge where `in_valid` & `in_ready` are both high; call it edge E.
- MixColumns path:
  - Columns 0..3 are written at edges E+1..E+4.
  - `out_valid` is high from E+4.
  - `busy` is high from E to E+4, i.e. during cycles E+1..E+4.
- Bypass path: `out_valid` is high from E+1, and `state_out` equals the captured `state_in`.
- Exit from DONE: `out_ready` high at edge D gives `out_valid`=0 and `in_ready`=1 after D.
  - The next acceptance is possible at D+1.
  - Minimum period is 6 cycles per MixColumns state and 3 per bypass state.
- Between edges E and E+4, `state_out` shows partially mixed data. It is valid only while `out_valid`=1.

## Configuration
- `MIXCOL_INV_EN` defined:
  - Adds port `in_inv` (in, 1), sampled with the transfer.
  - `in_inv`=1 selects InvMixColumns with coefficients 0e/0b/0d/09: r0'=e r0^b r1^d r2^9 r3, rotating per row like the forward transform.
  - Latency and handshake are identical to the forward transform.
  - `in_bypass`=1 overrides `in_inv`.
- `MIXCOL_INV_EN` undefined: the `in_inv` port is absent and only the forward transform is built.

## Test plan
- Reset then idle: after `rst`, `in_ready`=1, `out_valid`=0, `state_out`=0. With `in_valid`=0 for 10 cycles, nothing changes.
- Known vectors: all four columns set to 32'h135345db (db,13,53,45), `in_bypass`=0. Expected: every column = 32'h4da1bc8e, `out_valid` at E+4.
  - Repeat with column 32'h0a225cf2 → 32'hdc589d9f.
  - Repeat with 32'hd4d4d5d4 → 32'hd5d7d6d5.
  - Repeat with 32'hc6c6c6c6 → unchanged.
- Mixed columns and backpressure: the four columns above, one each. Hold `out_ready`=0 for 5 cycles after `out_valid`; the output stays stable. Assert `out_valid`=1 again with the next state presented while `out_ready`=1: no acceptance in DONE, and the next state is accepted at D+1.
- Bypass: `in_bypass`=1 with an arbitrary state gives the same state out, with `out_valid` at E+1 and `busy` never high.
- Reset mid-operation: assert `rst` at E+2. No `out_valid` follows and `state_out`=0. A new transfer afterwards completes normally with the correct result.
- `MIXCOL_INV_EN`: `in_inv`=1 with all columns 32'h4da1bc8e → all columns 32'h135345db at E+4. A forward pass followed by an inverse pass on random states returns the original state.
